// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage, valid/ready stream.
// Define CLA_PIPE_FLAGS_EN to add registered zero/neg result flags.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
`ifdef CLA_PIPE_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic             ovf
);

    localparam int NGRP = WIDTH / GROUP;

    // Returns {carry_out, sum} of one group with every carry expanded from G/P and the group carry-in.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i <= GROUP; i++) begin
            term = ci;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic [WIDTH-1:0]            bb_in;
    logic                        c0;
    logic                        en;
    logic [NGRP-1:0][WIDTH-1:0]  a_d, a_q, bb_d, bb_q;
    logic [NGRP-1:0]             cy_d, cy_q, vld_d, vld_q;
    logic                        ovf_d, ovf_q;
    logic                        unused_bb;

    assign bb_in = b ^ {WIDTH{sub}};
    assign c0    = cin ^ sub;

    // a_q[k] holds finished sum groups 0..k in place and untouched A operand groups above them,
    // so the last stage's a_q is the complete result.
    for (genvar k = 0; k < NGRP; k++) begin : stage
        localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}}) << (k * GROUP);
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] bb_src;
        logic             cy_src;
        logic             vld_src;
        logic [GROUP:0]   grp;

        if (k == 0) begin : from_in
            assign a_src   = a;
            assign bb_src  = bb_in;
            assign cy_src  = c0;
            assign vld_src = in_valid;
        end else begin : from_prev
            assign a_src   = a_q[k-1];
            assign bb_src  = bb_q[k-1];
            assign cy_src  = cy_q[k-1];
            assign vld_src = vld_q[k-1];
        end

        assign grp      = cla_group(a_src[k*GROUP +: GROUP], bb_src[k*GROUP +: GROUP], cy_src);
        assign a_d[k]   = (a_src & ~GMASK) | (WIDTH'(grp[GROUP-1:0]) << (k * GROUP));
        assign bb_d[k]  = bb_src;
        assign cy_d[k]  = grp[GROUP];
        assign vld_d[k] = vld_src;

        if (k == NGRP - 1) begin : last
            assign ovf_d = (a_src[WIDTH-1] == bb_src[WIDTH-1]) & (a_d[k][WIDTH-1] != a_src[WIDTH-1]);
        end
    end

    // Only the upper groups of each bb stage are consumed downstream.
    assign unused_bb = ^bb_q;

    assign out_valid = vld_q[NGRP-1];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            bb_q  <= '0;
            cy_q  <= '0;
            vld_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            a_q   <= a_d;
            bb_q  <= bb_d;
            cy_q  <= cy_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign res  = out_valid ? a_q[NGRP-1] : '0;
    assign cout = out_valid & cy_q[NGRP-1];
    assign ovf  = out_valid & ovf_q;

`ifdef CLA_PIPE_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (en) begin
            zero_q <= (a_d[NGRP-1] == '0);
            neg_q  <= a_d[NGRP-1][WIDTH-1];
        end
    end

    assign zero = out_valid & zero_q;
    assign neg  = out_valid & neg_q;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed 8/4 checks plus randomized 32/4 and 12/12 runs against an
// arithmetic reference model.
module tb_cla_pipe_addsub;

    localparam int NOPS = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        d8_in_valid, d8_in_ready, d8_cin, d8_sub, d8_out_valid, d8_out_ready, d8_cout, d8_ovf;
    logic [7:0]  d8_a, d8_b, d8_res;
    logic        d32_in_valid, d32_in_ready, d32_cin, d32_sub, d32_out_valid, d32_out_ready, d32_cout, d32_ovf;
    logic [31:0] d32_a, d32_b, d32_res;
    logic        d12_in_valid, d12_in_ready, d12_cin, d12_sub, d12_out_valid, d12_out_ready, d12_cout, d12_ovf;
    logic [11:0] d12_a, d12_b, d12_res;
`ifdef CLA_PIPE_FLAGS_EN
    logic        d8_zero, d8_neg, d32_zero, d32_neg, d12_zero, d12_neg;
`endif

    cla_pipe_addsub #(.WIDTH(8), .GROUP(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .res(d8_res), .cout(d8_cout),
`ifdef CLA_PIPE_FLAGS_EN
        .zero(d8_zero), .neg(d8_neg),
`endif
        .ovf(d8_ovf));

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
        .a(d32_a), .b(d32_b), .cin(d32_cin), .sub(d32_sub),
        .out_valid(d32_out_valid), .out_ready(d32_out_ready), .res(d32_res), .cout(d32_cout),
`ifdef CLA_PIPE_FLAGS_EN
        .zero(d32_zero), .neg(d32_neg),
`endif
        .ovf(d32_ovf));

    cla_pipe_addsub #(.WIDTH(12), .GROUP(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(d12_in_valid), .in_ready(d12_in_ready),
        .a(d12_a), .b(d12_b), .cin(d12_cin), .sub(d12_sub),
        .out_valid(d12_out_valid), .out_ready(d12_out_ready), .res(d12_res), .cout(d12_cout),
`ifdef CLA_PIPE_FLAGS_EN
        .zero(d12_zero), .neg(d12_neg),
`endif
        .ovf(d12_ovf));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {ovf, cout, res} from integer arithmetic: unsigned sum for res/cout, signed range test for ovf.
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        longint mask, half, ua, ub, c0, sum, sa, sb, ss;
        logic [33:0] r;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        ua    = longint'(x) & mask;
        ub    = (s ? ~longint'(y) : longint'(y)) & mask;
        c0    = (ci ^ s) ? 1 : 0;
        sum   = ua + ub + c0;
        sa    = (ua >= half) ? ua - 2 * half : ua;
        sb    = (ub >= half) ? ub - 2 * half : ub;
        ss    = sa + sb + c0;
        r[31:0] = 32'(sum & mask);
        r[32]   = ((sum >> w) & 1) != 0;
        r[33]   = (ss >= half) || (ss < -half);
        return r;
    endfunction

    function automatic logic [33:0] pack8();
        return {d8_ovf, d8_cout, 24'd0, d8_res};
    endfunction

    task automatic op8(input string name, input logic [7:0] x, input logic [7:0] y, input logic ci,
                       input logic s, input logic [7:0] er, input logic ec, input logic eo);
        @(negedge clk);
        d8_a = x; d8_b = y; d8_cin = ci; d8_sub = s;
        d8_in_valid = 1'b1; d8_out_ready = 1'b1;
        #1 chk({name, "_in_ready"}, d8_in_ready, 1);
        @(negedge clk);
        d8_in_valid = 1'b0;
        chk({name, "_not_yet"}, d8_out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, d8_out_valid, 1);
        chk({name, "_res"}, d8_res, er);
        chk({name, "_cout"}, d8_cout, ec);
        chk({name, "_ovf"}, d8_ovf, eo);
`ifdef CLA_PIPE_FLAGS_EN
        chk({name, "_zero"}, d8_zero, er == 8'h00);
        chk({name, "_neg"}, d8_neg, er[7]);
`endif
    endtask

    logic [7:0] sa8 [4] = '{8'h12, 8'hF0, 8'h50, 8'hAA};
    logic [7:0] sb8 [4] = '{8'h34, 8'h20, 8'h60, 8'h55};
    logic       sc8 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ss8 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int          idx, got, stall_left, seen;
        bit          stalled;
        logic [33:0] held, exp_c;

        rst_n = 1'b0;
        {d8_in_valid, d8_cin, d8_sub, d8_out_ready, d8_a, d8_b} = '0;
        {d32_in_valid, d32_cin, d32_sub, d32_out_ready, d32_a, d32_b} = '0;
        {d12_in_valid, d12_cin, d12_sub, d12_out_ready, d12_a, d12_b} = '0;

        chk("model_ff_01",   model(8, 32'hFF, 32'h01, 1'b0, 1'b0),        34'h1_0000_0000);
        chk("model_7f_01",   model(8, 32'h7F, 32'h01, 1'b0, 1'b0),        34'h2_0000_0080);
        chk("model_sub_min", model(8, 32'h80, 32'h01, 1'b0, 1'b1),        34'h3_0000_007F);
        chk("model_w32",     model(32, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0), 34'h1_0000_0000);
        chk("model_w12_sub", model(12, 32'h800, 32'h001, 1'b0, 1'b1),     34'h3_0000_07FF);

        #12;
        chk("reset_out_valid", d8_out_valid, 0);
        chk("reset_res", pack8(), 0);
        chk("reset_in_ready", d8_in_ready, 1);
        chk("reset_out_valid32", d32_out_valid, 0);
        chk("reset_out_valid12", d12_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0 ^ 1'b1, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_cin",   8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        op8("sub_5_7",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_min",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Four back-to-back ops with a three-cycle output stall once the first result shows.
        idx = 0; got = 0; stall_left = 0; stalled = 0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (d8_out_valid && !stalled) begin
                stalled = 1; stall_left = 3; held = pack8();
            end
            d8_out_ready = (stall_left == 0);
            d8_in_valid  = (idx < 4);
            if (idx < 4) begin
                d8_a = sa8[idx]; d8_b = sb8[idx]; d8_cin = sc8[idx]; d8_sub = ss8[idx];
            end
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", d8_in_ready, 0);
                chk("stall_hold", pack8(), held);
                stall_left--;
            end
            if (d8_in_valid && d8_in_ready) idx++;
            if (d8_out_valid && d8_out_ready) begin
                chk("stream_res", pack8(), model(8, 32'(sa8[got]), 32'(sb8[got]), sc8[got], ss8[got]));
                got++;
            end
        end
        chk("stream_count", got, 4);
        chk("stream_stalled", stalled, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d8_in_valid = 1'b0;
            chk("stream_no_dup", d8_out_valid, 0);
        end

        // Reset with two ops in flight.
        @(negedge clk);
        d8_a = 8'h11; d8_b = 8'h22; d8_cin = 0; d8_sub = 0; d8_in_valid = 1; d8_out_ready = 1;
        @(negedge clk);
        d8_a = 8'h33; d8_b = 8'h44;
        @(negedge clk);
        d8_in_valid = 0; d8_out_ready = 0;
        chk("rst_pre_valid", d8_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", d8_out_valid, 0);
        chk("rst_res_zero", pack8(), 0);
        chk("rst_in_ready", d8_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d8_a = 8'h5A; d8_b = 8'h0F; d8_cin = 1; d8_sub = 1; d8_in_valid = 1; d8_out_ready = 1;
        exp_c = model(8, 32'h5A, 32'h0F, 1'b1, 1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d8_in_valid = 0;
            if (d8_out_valid) begin
                seen++;
                chk("rst_after_res", pack8(), exp_c);
            end
        end
        chk("rst_single_result", seen, 1);

        fork
            begin : rnd32
                logic [33:0] q[$];
                int sent, cyc;
                sent = 0; cyc = 0;
                while ((sent < NOPS || q.size() != 0) && cyc < NOPS * 4) begin
                    @(negedge clk);
                    cyc++;
                    d32_out_ready = ($urandom_range(0, 3) != 0);
                    d32_in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                    d32_a = $urandom; d32_b = $urandom;
                    if ($urandom_range(0, 7) == 0) d32_a = 32'h7FFF_FFFF + 32'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) d32_b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
                    d32_cin = 1'($urandom_range(0, 1)); d32_sub = 1'($urandom_range(0, 1));
                    #1;
                    chk("rnd32_in_ready", d32_in_ready, !d32_out_valid || d32_out_ready);
                    if (d32_out_valid) begin
                        chk("rnd32_pending", q.size() != 0, 1);
                        if (q.size() != 0) begin
                            chk("rnd32_res", {d32_ovf, d32_cout, d32_res}, q[0]);
                            if (d32_out_ready) void'(q.pop_front());
                        end
                    end else begin
                        chk("rnd32_idle_zero", {d32_ovf, d32_cout, d32_res}, 0);
                    end
                    if (d32_in_valid && d32_in_ready) begin
                        q.push_back(model(32, d32_a, d32_b, d32_cin, d32_sub));
                        sent++;
                    end
                end
                d32_in_valid = 0;
                chk("rnd32_drained", (sent == NOPS) && (q.size() == 0), 1);
            end
            begin : rnd12
                logic [33:0] q[$];
                int sent, cyc;
                sent = 0; cyc = 0;
                while ((sent < NOPS || q.size() != 0) && cyc < NOPS * 4) begin
                    @(negedge clk);
                    cyc++;
                    d12_out_ready = ($urandom_range(0, 3) != 0);
                    d12_in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                    d12_a = 12'($urandom); d12_b = 12'($urandom);
                    if ($urandom_range(0, 7) == 0) d12_a = 12'h7FF + 12'($urandom_range(0, 1));
                    d12_cin = 1'($urandom_range(0, 1)); d12_sub = 1'($urandom_range(0, 1));
                    #1;
                    chk("rnd12_in_ready", d12_in_ready, !d12_out_valid || d12_out_ready);
                    if (d12_out_valid) begin
                        chk("rnd12_pending", q.size() != 0, 1);
                        if (q.size() != 0) begin
                            chk("rnd12_res", {d12_ovf, d12_cout, 20'd0, d12_res}, q[0]);
                            if (d12_out_ready) void'(q.pop_front());
                        end
                    end else begin
                        chk("rnd12_idle_zero", {d12_ovf, d12_cout, d12_res}, 0);
                    end
                    if (d12_in_valid && d12_in_ready) begin
                        q.push_back(model(12, 32'(d12_a), 32'(d12_b), d12_cin, d12_sub));
                        sent++;
                    end
                end
                d12_in_valid = 0;
                chk("rnd12_drained", (sent == NOPS) && (q.size() == 0), 1);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
